// File: rtl/fp32_mul_pkg.sv
// Shared definitions for the FP32 multiplier normalize/round stage.
// Holds the IEEE-754 single-precision constants and the stage1 payload
// struct passed from the normalize register to the round/pack logic.
package fp32_mul_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int FRAC_W   = 23;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Width of the exponent carried in the stage1 payload; matches the
  // default EXP_W of the top level.
  localparam int PL_EXP_W = 10;

  // Normalized operand waiting for rounding. e is a two's-complement
  // biased exponent; tiny marks a result below the normal range.
  typedef struct packed {
    logic                sign;
    logic                special;
    logic [31:0]         special_val;
    logic [PL_EXP_W-1:0] e;
    logic [FRAC_W-1:0]   m;
    logic                g;
    logic                s;
    logic                tiny;
  } s1_payload_t;

endpackage

// File: rtl/fp32_rne_round.sv
// Combinational round-to-nearest-even and pack unit.
// Optional feature macro: FP32_MUL_SUBNORMAL_EN (gradual underflow);
// without it, tiny results flush to signed zero.
// Ports:
//   sign      result sign
//   e         signed biased exponent of the normalized value
//   m, g, s   23-bit fraction, guard bit, sticky bit
//   tiny      value lies below the normal range (exponent <= 0)
//   result    packed FP32 result
//   overflow  rounded to infinity
//   underflow tiny result (flushed, or tiny and inexact)
//   inexact   precision was lost
module fp32_rne_round
  import fp32_mul_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic              sign,
  input  logic [EXP_W-1:0]  e,
  input  logic [FRAC_W-1:0] m,
  input  logic              g,
  input  logic              s,
  input  logic              tiny,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  localparam logic signed [EXP_W-1:0] E_MAX_S = EXP_W'(EXP_MAX);

  logic                    up;
  logic [FRAC_W:0]         sum;
  logic signed [EXP_W-1:0] e_r;

  always_comb begin
    up  = g & (s | m[0]);
    sum = {1'b0, m} + {{FRAC_W{1'b0}}, up};
    // A carry out of the fraction means the significand rolled over to
    // 2.0: fraction becomes 0 (already true in sum) and exponent bumps.
    e_r = $signed(e) + $signed({{(EXP_W-1){1'b0}}, sum[FRAC_W]});

    result    = {sign, e_r[7:0], sum[FRAC_W-1:0]};
    overflow  = 1'b0;
    underflow = 1'b0;
    inexact   = g | s;

    if (tiny) begin
`ifdef FP32_MUL_SUBNORMAL_EN
      // Exponent arrives as 0; a rounding carry lifts it to 1 (smallest
      // normal), which the generic pack above already produces.
      underflow = g | s;
`else
      result    = {sign, 31'b0};
      underflow = 1'b1;
      inexact   = 1'b1;
`endif
    end else if (e_r >= E_MAX_S) begin
      result   = {sign, 8'hFF, 23'b0};
      overflow = 1'b1;
      inexact  = 1'b1;
    end
  end

endmodule

// File: rtl/fp32_mul_norm_round.sv
// FP32 multiplier back end: normalize (stage1), round-to-nearest-even
// and pack (stage2). Two register stages, one result per cycle.
// Optional feature macro: FP32_MUL_SUBNORMAL_EN enables gradual
// underflow (denormalized results); default build flushes to zero.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   in_valid_i/ready_o  upstream handshake
//   sign_i, exp_i       result sign, signed biased exponent for [1,2)
//   product_i           raw 2*MANT_W-bit significand product
//   special_i/_val_i    pre-resolved NaN/Inf/zero result to forward
//   out_valid_o/ready_i downstream handshake
//   result_o            packed FP32 result
//   overflow_o, underflow_o, inexact_o  exception flags
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. The whole pipe advances when the output register is
// empty or being drained (en); in_ready_o is that same enable, so while
// out_valid_o=1 and out_ready_i=0 every register and output holds.
module fp32_mul_norm_round
  import fp32_mul_pkg::*;
#(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  sign_i,
  input  logic [EXP_W-1:0]      exp_i,
  input  logic [2*MANT_W-1:0]   product_i,
  input  logic                  special_i,
  input  logic [31:0]           special_val_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           result_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic                  inexact_o
);

  localparam int P_W = 2 * MANT_W;
  localparam logic signed [EXP_W-1:0] E_ZERO = '0;
  localparam logic signed [EXP_W-1:0] E_ONE  = EXP_W'(1);
`ifdef FP32_MUL_SUBNORMAL_EN
  // Exponents at or below this shift everything into sticky.
  localparam logic signed [EXP_W-1:0] E_CLAMP = EXP_W'(-25);
  logic [EXP_W-1:0]    sh_amt;
  logic [2*FRAC_W+3:0] sh_vec;
`endif

  logic                    en;
  logic                    s1_valid;
  s1_payload_t             s1_d, s1_q;
  logic signed [EXP_W-1:0] n_e;
  logic [FRAC_W-1:0]       n_m;
  logic                    n_g, n_s, n_tiny;

  logic [31:0] rnd_result;
  logic        rnd_overflow, rnd_underflow, rnd_inexact;

  assign en         = ~out_valid_o | out_ready_i;
  assign in_ready_o = en;

  // Stage1: normalize the product into [1,2) and extract guard/sticky.
  always_comb begin
    if (product_i[P_W-1]) begin
      n_m = product_i[P_W-2 -: FRAC_W];
      n_g = product_i[MANT_W-1];
      n_s = |product_i[MANT_W-2:0];
      n_e = $signed(exp_i) + E_ONE;
    end else begin
      n_m = product_i[P_W-3 -: FRAC_W];
      n_g = product_i[MANT_W-2];
      n_s = |product_i[MANT_W-3:0];
      n_e = $signed(exp_i);
    end
    n_tiny = (n_e <= E_ZERO);
`ifdef FP32_MUL_SUBNORMAL_EN
    sh_amt = '0;
    sh_vec = '0;
    if (n_tiny) begin
      if (n_e <= E_CLAMP) begin
        n_m = '0;
        n_g = 1'b0;
        n_s = 1'b1;
      end else begin
        // Total right shift is 1-E; placing the hidden bit at the top of
        // the window and reading the fraction one bit lower accounts for
        // the first position, so the barrel shift itself is -E.
        sh_amt = E_ZERO - n_e;
        sh_vec = {1'b1, n_m, n_g, 25'b0} >> sh_amt;
        n_m    = sh_vec[2*FRAC_W+3 -: FRAC_W];
        n_g    = sh_vec[FRAC_W+3];
        n_s    = n_s | (|sh_vec[FRAC_W+2:0]);
      end
      n_e = E_ZERO;
    end
`endif
    s1_d.sign        = sign_i;
    s1_d.special     = special_i;
    s1_d.special_val = special_val_i;
    s1_d.e           = n_e;
    s1_d.m           = n_m;
    s1_d.g           = n_g;
    s1_d.s           = n_s;
    s1_d.tiny        = n_tiny;
  end

  // Stage2 combinational round and pack.
  fp32_rne_round #(
    .EXP_W(EXP_W)
  ) u_round (
    .sign      (s1_q.sign),
    .e         (s1_q.e),
    .m         (s1_q.m),
    .g         (s1_q.g),
    .s         (s1_q.s),
    .tiny      (s1_q.tiny),
    .result    (rnd_result),
    .overflow  (rnd_overflow),
    .underflow (rnd_underflow),
    .inexact   (rnd_inexact)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      inexact_o   <= 1'b0;
    end else if (en) begin
      s1_valid    <= in_valid_i;
      s1_q        <= s1_d;
      out_valid_o <= s1_valid;
      // Bubbles load zeros so a stale payload never shows up as flags.
      if (!s1_valid) begin
        result_o    <= '0;
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
        inexact_o   <= 1'b0;
      end else if (s1_q.special) begin
        result_o    <= s1_q.special_val;
        overflow_o  <= 1'b0;
        underflow_o <= 1'b0;
        inexact_o   <= 1'b0;
      end else begin
        result_o    <= rnd_result;
        overflow_o  <= rnd_overflow;
        underflow_o <= rnd_underflow;
        inexact_o   <= rnd_inexact;
      end
    end
  end

  // A non-special product must have one of its top two bits set.
  always @(posedge clk_i) begin
    if (!rst_i && in_valid_i && en && !special_i)
      assert (product_i[P_W-1 -: 2] != 2'b00);
  end

endmodule

// File: tb/tb_fp32_mul_norm_round.sv
// Bench for fp32_mul_norm_round: directed vectors, backpressure, mid-flight
// reset and randomized operands checked against an arithmetic reference.
module tb_fp32_mul_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [9:0]  exp_v = '0;
  logic [47:0] product = '0;
  logic        special = 1'b0;
  logic [31:0] special_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, underflow, inexact;

  // Scoreboard entries: {result, overflow, underflow, inexact}
  logic [34:0] exp_q[$];
  logic [34:0] mon_w;
  logic [34:0] held;
  int          errors = 0;
  int          checks = 0;
  logic        rand_done;

  fp32_mul_norm_round dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .sign_i        (sign),
    .exp_i         (exp_v),
    .product_i     (product),
    .special_i     (special),
    .special_val_i (special_val),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .result_o      (result),
    .overflow_o    (overflow),
    .underflow_o   (underflow),
    .inexact_o     (inexact)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Value = product * 2^(exp-46); keep 24 significant bits (fewer when
  // tiny and subnormals are enabled) and round the remainder to nearest
  // even with plain integer arithmetic.
  function automatic logic [34:0] ref_model(input logic s, input int e_in,
                                            input logic [47:0] p, input logic sp,
                                            input logic [31:0] sv);
    logic [127:0] pw, q, r, half;
    int lead, k, e, e_enc;
    logic tiny, inx;
    if (sp) return {sv, 3'b000};
    lead = p[47] ? 47 : 46;
    e    = e_in + (lead - 46);
    k    = lead - 23;
    tiny = (e <= 0);
`ifdef FP32_MUL_SUBNORMAL_EN
    if (tiny) begin
      k     = k + 1 - e;
      e_enc = 0;
    end else begin
      e_enc = e;
    end
`else
    if (tiny) return {s, 31'b0, 3'b011};
    e_enc = e;
`endif
    if (k > 100) k = 100;
    pw   = 128'(p);
    q    = pw >> k;
    r    = pw - (q << k);
    half = 128'(1) << (k - 1);
    inx  = (r != 0);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q[24]) begin
      q     = q >> 1;
      e_enc = e_enc + 1;
    end else if (tiny && q[23]) begin
      e_enc = 1;
    end
    if (e_enc >= 255) return {s, 8'hFF, 23'b0, 3'b101};
    return {s, 8'(e_enc), q[22:0], 1'b0, tiny & inx, inx};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Output monitor: a result transfers on the edge after a negedge where
  // out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output: observed %0h expected none", result);
      end else begin
        mon_w = exp_q.pop_front();
        check("scoreboard", {29'b0, result, overflow, underflow, inexact}, {29'b0, mon_w});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driving happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input int e, input logic [47:0] p,
                      input logic sp, input logic [31:0] sv,
                      input logic use_fixed, input logic [34:0] fixed);
    int budget;
    budget      = 300;
    sign        = s;
    exp_v       = 10'(e);
    product     = p;
    special     = sp;
    special_val = sv;
    in_valid    = 1'b1;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      step();
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: in_ready observed 0 expected 1");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(use_fixed ? fixed : ref_model(s, e, p, sp, sv));
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [63:0] r64;
    logic [47:0] p;
    int e;
    logic sp;
    r64 = {$urandom(), $urandom()};
    p   = r64[47:0];
    if (p[47:46] == 2'b00) p[46] = 1'b1;
    if ($urandom_range(0, 1) == 1)
      e = int'($urandom_range(0, 400)) - 100;
    else
      case ($urandom_range(0, 7))
        0: e = -25;
        1: e = -24;
        2: e = 0;
        3: e = 1;
        4: e = 126;
        5: e = 127;
        6: e = 253;
        default: e = 254;
      endcase
    sp = ($urandom_range(0, 7) == 0);
    send(1'($urandom_range(0, 1)), e, p, sp, $urandom(), 1'b0, '0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({overflow, underflow, inexact}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;
    step();

    // 1.5 * 1.5 with exact latency
    send(1'b0, 127, 48'h900000000000, 1'b0, '0, 1'b1, {32'h40100000, 3'b000});
    @(negedge clk);
    check("latency_cycle1", 64'(out_valid), 64'd0);
    step();
    @(negedge clk);
    check("latency_cycle2", 64'(out_valid), 64'd1);
    step();
    drain("drain_mult15");

    // rounding, overflow, special, underflow
    send(1'b0, 127, 48'h7FFFFFC00000, 1'b0, '0, 1'b1, {32'h40000000, 3'b001});
    send(1'b0, 127, 48'h400000400000, 1'b0, '0, 1'b1, {32'h3F800000, 3'b001});
    send(1'b0, 254, 48'h800000000000, 1'b0, '0, 1'b1, {32'h7F800000, 3'b101});
    send(1'b0, 5, 48'h0, 1'b1, 32'h7FC00000, 1'b1, {32'h7FC00000, 3'b000});
`ifdef FP32_MUL_SUBNORMAL_EN
    send(1'b1, 0, 48'h400000000000, 1'b0, '0, 1'b1, {32'h80400000, 3'b000});
`else
    send(1'b1, 0, 48'h400000000000, 1'b0, '0, 1'b1, {32'h80000000, 3'b011});
`endif
    drain("drain_directed");

    // backpressure: 4 back-to-back inputs, output stalled for 3 cycles
    out_ready = 1'b1;
    fork
      begin
        repeat (4) send_rand();
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
          step();
          n++;
        end
        check("stall_start", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        held = {result, overflow, underflow, inexact};
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          check("stall_hold", 64'({result, overflow, underflow, inexact}), 64'(held));
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // reset with two operations in flight
    out_ready = 1'b0;
    send_rand();
    send_rand();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_flags", 64'({overflow, underflow, inexact}), 64'd0);
    step();
    out_ready = 1'b1;
    send(1'b0, 127, 48'h900000000000, 1'b0, '0, 1'b1, {32'h40100000, 3'b000});
    drain("drain_after_reset");

    // randomized stream with random downstream backpressure
    rand_done = 1'b0;
    fork
      begin
        repeat (200) send_rand();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    repeat (3) step();
    @(negedge clk);
    check("final_idle", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp32_mul_norm_round.md
Name: fp32_mul_norm_round

Overview:
- Downstream stage of the FP32 multiplier datapath.
- Consumes the 48-bit unsigned mantissa product from the Karatsuba/Booth core, together with sign, pre-computed exponent and special-case info from the unpack stage.
- Normalizes, rounds to nearest-even, detects overflow/underflow and emits a packed IEEE-754 single.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 10, width of the signed biased exponent input (two's complement).
- MANT_W, 24, significand width incl. hidden bit; product width is 2*MANT_W.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  upstream operand valid.
- in_ready_o  out  1  block can accept this cycle.
- sign_i  in  1  result sign (sA ^ sB).
- exp_i  in  EXP_W  signed eA+eB-127, assuming product in [1,2).
- product_i  in  2*MANT_W  raw mantissa product, hidden bits included.
- special_i  in  1  operand pair is NaN/Inf/zero, resolved upstream.
- special_val_i  in  32  packed result to forward when special_i=1.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts.
- result_o  out  32  packed FP32 result.
- overflow_o  out  1  result overflowed to infinity.
- underflow_o  out  1  tiny result (see Behaviour).
- inexact_o  out  1  guard or sticky was nonzero.

Behaviour:
- Reset: both stage valids=0; out_valid_o=0; result_o=0; all flags=0. A reset asserted mid-operation discards in-flight data with no output produced.
- Pipeline control:
  - Global advance en = ~out_valid_o | out_ready_i; in_ready_o = en.
  - On en, stage1 captures input and stage2 captures stage1, both with their valid bits. Bubbles propagate.
  - While out_valid_o=1 and out_ready_i=0, every register holds and result_o/flags stay stable.
- Latency: 2 cycles from an accepted input to out_valid_o. Throughput is 1/cycle when out_ready_i=1.
- Stage1 (normalize):
  - If product_i[47]=1: M=p[46:24], G=p[23], S=|p[22:0], E=exp_i+1.
  - Else: M=p[45:23], G=p[22], S=|p[21:0], E=exp_i.
  - product_i[47:46]=00 is illegal when special_i=0 (simulation assertion).
- Stage2 (round, RNE):
  - up = G & (S | M[0]); M' = M + up.
  - If the 23-bit increment carries out: M'=0, E=E+1.
  - Final check: E>=255 gives {sign,8'hFF,23'h0} with overflow_o=1, inexact_o=1.
  - E<=0 handling is described under Optional Feature.
  - Otherwise the result is {sign,E[7:0],M'} and inexact_o = G|S.
- special_i=1: result_o = special_val_i, all flags 0; normalize/round logic is bypassed.
- Exponent arithmetic is carried at EXP_W bits signed throughout; no wrap is allowed.

Optional Feature:
- Macro: FP32_MUL_SUBNORMAL_EN.
- Defined (gradual underflow):
  - In stage1, when E<=0, the significand {1,M} plus G/S is shifted right by 1-E; shifted-out bits OR into sticky.
  - A shift >=26 yields M=0, G=0, S=1.
  - Encoded exponent is 0. If rounding carries into bit 23, the encoded exponent becomes 1 (normal).
  - underflow_o = tiny & inexact.
- Undefined (flush-to-zero):
  - E<=0 gives signed zero {sign,31'h0} with underflow_o=1 and inexact_o=1.

Decomposition:
- Package fp32_mul_pkg holds:
  - constants EXP_BIAS=127, EXP_MAX=255, FRAC_W=23, QNAN=32'h7FC00000;
  - a typedef for the stage1 payload struct {sign, special, special_val, E, M, G, S}.
- One natural sub-module: fp32_rne_round, a combinational round-and-pack unit (M,G,S,E,sign in; result and flags out) used by stage2.

Test Plan:
- 1.5*1.5: product_i=48'h900000000000, exp_i=127, sign 0 -> result 32'h40100000, all flags 0, valid exactly 2 cycles after accept.
- Tie rounds up with carry: product_i=48'h7FFFFFC00000, exp_i=127 -> result 32'h40000000, inexact_o=1. Tie stays even: product_i=48'h400000400000 -> 32'h3F800000, inexact_o=1.
- Overflow: product_i=48'h800000000000, exp_i=254 -> 32'h7F800000, overflow_o=1. Special: special_i=1, special_val_i=32'h7FC00000 -> forwarded unchanged, flags 0.
- Underflow: product_i=48'h400000000000, exp_i=0, sign 1 -> FTZ build: 32'h80000000 with underflow_o=1; FP32_MUL_SUBNORMAL_EN build: 32'h80400000 with underflow_o=0.
- Backpressure: stream 4 back-to-back inputs and hold out_ready_i=0 for 3 cycles -> in_ready_o=0, result_o stable while stalled, all 4 results delivered in order with none lost or duplicated.
- Assert rst_i for 1 cycle with 2 ops in flight -> next cycle out_valid_o=0, result_o=0; subsequent inputs behave normally.
